// File: rtl/lut_func_unit_if.sv
// Bundle of configuration, evaluation and result signals for lut_func_unit.
// The master side drives writes and requests; the slave side is the LUT unit.
interface lut_func_unit_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
);
  logic             cfg_we;
  logic [N_IN-1:0]  cfg_addr;
  logic [N_OUT-1:0] cfg_data;
  logic             in_valid;
  logic [N_IN-1:0]  in_data;
  logic             sweep_start;
  logic             out_valid;
  logic [N_OUT-1:0] out_data;
  logic [N_IN-1:0]  out_idx;
  logic             sweep_busy;
  logic             sweep_done;

  modport master (
    output cfg_we, cfg_addr, cfg_data, in_valid, in_data, sweep_start,
    input  out_valid, out_data, out_idx, sweep_busy, sweep_done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, in_valid, in_data, sweep_start,
    output out_valid, out_data, out_idx, sweep_busy, sweep_done
  );
endinterface

// File: rtl/lut_func_unit.sv
// Register-based truth-table function unit: single evaluations with one-cycle
// latency, plus an exhaustive sweep that streams every table entry in order.
module lut_func_unit #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 2
) (
  input  logic               clk,
  input  logic               rst_b,
  lut_func_unit_if.slave     bus
);

  localparam int DEPTH = 1 << N_IN;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state, state_n;
  logic [N_IN-1:0]  cnt, cnt_n;
  logic [N_OUT-1:0] lut [DEPTH];

  logic             out_valid_q, out_valid_n;
  logic [N_OUT-1:0] out_data_q, out_data_n;
  logic [N_IN-1:0]  out_idx_q, out_idx_n;
  logic             sweep_done_q, sweep_done_n;
  logic             wr_en;

  // Writes are only honoured while idle so a sweep always sees a stable table.
  assign wr_en = (state == IDLE) && bus.cfg_we;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        lut[i] <= '0;
      end
    end else if (wr_en) begin
      lut[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state        <= IDLE;
      cnt          <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      out_valid_q  <= out_valid_n;
      out_data_q   <= out_data_n;
      out_idx_q    <= out_idx_n;
      sweep_done_q <= sweep_done_n;
    end
  end

  // The table read happens before any same-edge write lands, which gives
  // read-old-value behaviour for a simultaneous write and evaluation.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    out_valid_n  = 1'b0;
    out_data_n   = out_data_q;
    out_idx_n    = out_idx_q;
    sweep_done_n = 1'b0;
    case (state)
      IDLE: begin
        if (bus.sweep_start) begin
          state_n = RUN;
          cnt_n   = '0;
        end else if (bus.in_valid) begin
          out_valid_n = 1'b1;
          out_idx_n   = bus.in_data;
          out_data_n  = lut[bus.in_data];
        end
      end
      RUN: begin
        out_valid_n = 1'b1;
        out_idx_n   = cnt;
        out_data_n  = lut[cnt];
        cnt_n       = cnt + 1'b1;
        if (&cnt) begin
          state_n      = IDLE;
          sweep_done_n = 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_idx    = out_idx_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.sweep_busy = (state == RUN);

endmodule

// File: tb/tb_lut_func_unit.sv
// Self-checking bench for lut_func_unit: directed vector table, sweep corner
// sequences, and randomized traffic compared against a queue-based model.
module tb_lut_func_unit;

  logic clk;
  logic rst_b;
  int   checks;
  int   errors;

  lut_func_unit_if #(.N_IN(4), .N_OUT(2)) bus ();

  lut_func_unit #(.N_IN(4), .N_OUT(2)) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       valid;
    logic [3:0] idx;
    logic [1:0] data;
    logic       done;
  } out_t;

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [1:0] cdata;
    logic       iv;
    logic [3:0] idata;
    logic       exp_valid;
    logic [3:0] exp_idx;
    logic [1:0] exp_data;
  } vec_t;

  // The model: a plain table plus a schedule of results still owed by a sweep.
  logic [1:0] m_lut [16];
  out_t       sched [$];
  out_t       m_exp;
  logic       m_busy;
  vec_t       vecs [$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) m_lut[i] = 2'b00;
    sched.delete();
    m_exp  = '{1'b0, 4'd0, 2'd0, 1'b0};
    m_busy = 1'b0;
  endfunction

  function automatic void model_edge(input logic we, input logic [3:0] addr, input logic [1:0] cd,
                                     input logic iv, input logic [3:0] id, input logic st);
    if (!rst_b) begin
      model_reset();
      return;
    end
    if (sched.size() > 0) begin
      m_exp = sched.pop_front();
    end else begin
      m_exp = '{1'b0, 4'd0, 2'd0, 1'b0};
      if (!st && iv) m_exp = '{1'b1, id, m_lut[id], 1'b0};
      if (we) m_lut[addr] = cd;
      if (st) begin
        for (int k = 0; k < 16; k++) sched.push_back('{1'b1, 4'(k), m_lut[k], k == 15});
      end
    end
    m_busy = (sched.size() > 0);
  endfunction

  task automatic applyStimulus(input logic we, input logic [3:0] addr, input logic [1:0] cd,
                               input logic iv, input logic [3:0] id, input logic st);
    bus.cfg_we      = we;
    bus.cfg_addr    = addr;
    bus.cfg_data    = cd;
    bus.in_valid    = iv;
    bus.in_data     = id;
    bus.sweep_start = st;
    model_edge(we, addr, cd, iv, id, st);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b0);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, " out_valid"}, 8'(bus.out_valid), 8'(m_exp.valid));
    chk({tag, " sweep_done"}, 8'(bus.sweep_done), 8'(m_exp.done));
    chk({tag, " sweep_busy"}, 8'(bus.sweep_busy), 8'(m_busy));
    if (m_exp.valid) begin
      chk({tag, " out_idx"}, 8'(bus.out_idx), 8'(m_exp.idx));
      chk({tag, " out_data"}, 8'(bus.out_data), 8'(m_exp.data));
    end
  endtask

  function automatic void add_vec(input logic we, input logic [3:0] addr, input logic [1:0] cd,
                                  input logic iv, input logic [3:0] id,
                                  input logic ev, input logic [3:0] ei, input logic [1:0] ed);
    vecs.push_back('{we, addr, cd, iv, id, ev, ei, ed});
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [3:0] k;
    checks = 0;
    errors = 0;
    rst_b  = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_data = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.sweep_start = 1'b0;
    model_reset();

    // Directed vectors: reset read of entry 5, table fill, spot reads, write/read collision.
    add_vec(1'b0, 4'd0, 2'd0, 1'b1, 4'd5, 1'b1, 4'd5, 2'b00);
    for (int i = 0; i < 16; i++) begin
      k = 4'(i);
      add_vec(1'b1, k, {~(k[1] ^ k[0]), ~k[0]}, 1'b0, 4'd0, 1'b0, 4'd0, 2'b00);
    end
    add_vec(1'b0, 4'd0, 2'd0, 1'b1, 4'd0, 1'b1, 4'd0, 2'b11);
    add_vec(1'b0, 4'd0, 2'd0, 1'b1, 4'd1, 1'b1, 4'd1, 2'b00);
    add_vec(1'b0, 4'd0, 2'd0, 1'b1, 4'd2, 1'b1, 4'd2, 2'b01);
    add_vec(1'b0, 4'd0, 2'd0, 1'b1, 4'd3, 1'b1, 4'd3, 2'b10);
    add_vec(1'b1, 4'd7, 2'b00, 1'b0, 4'd0, 1'b0, 4'd0, 2'b00);
    add_vec(1'b1, 4'd7, 2'b11, 1'b1, 4'd7, 1'b1, 4'd7, 2'b00);
    add_vec(1'b0, 4'd0, 2'd0, 1'b1, 4'd7, 1'b1, 4'd7, 2'b11);

    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset out_valid", 8'(bus.out_valid), 8'd0);
    chk("reset out_data", 8'(bus.out_data), 8'd0);
    chk("reset out_idx", 8'(bus.out_idx), 8'd0);
    chk("reset sweep_done", 8'(bus.sweep_done), 8'd0);
    chk("reset sweep_busy", 8'(bus.sweep_busy), 8'd0);
    rst_b = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].we, vecs[i].addr, vecs[i].cdata, vecs[i].iv, vecs[i].idata, 1'b0);
      chk($sformatf("vec%0d out_valid", i), 8'(bus.out_valid), 8'(vecs[i].exp_valid));
      if (vecs[i].exp_valid) begin
        chk($sformatf("vec%0d out_idx", i), 8'(bus.out_idx), 8'(vecs[i].exp_idx));
        chk($sformatf("vec%0d out_data", i), 8'(bus.out_data), 8'(vecs[i].exp_data));
      end
    end

    // Clean sweep of the configured table.
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b1);
    checkOutput("sweep start");
    for (int i = 0; i < 16; i++) begin
      idle_cycle();
      checkOutput($sformatf("sweep %0d", i));
    end
    chk("sweep last idx", 8'(bus.out_idx), 8'd15);
    idle_cycle();
    checkOutput("after sweep");

    // Sweep with every request held active; restart is taken only after the return edge.
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b1);
    checkOutput("noisy start");
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 4'($urandom_range(15)), 2'($urandom_range(3)), 1'b1,
                    4'($urandom_range(15)), 1'b1);
      checkOutput($sformatf("noisy %0d", i));
    end
    for (int i = 0; i < 20; i++) begin
      idle_cycle();
      checkOutput($sformatf("drain %0d", i));
    end
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 4'(i), 1'b0);
      checkOutput($sformatf("table read %0d", i));
    end

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      applyStimulus(($urandom_range(3) == 0), 4'($urandom_range(15)), 2'($urandom_range(3)),
                    1'($urandom_range(1)), 4'($urandom_range(15)), ($urandom_range(24) == 0));
      checkOutput($sformatf("rand %0d", i));
    end
    for (int i = 0; i < 18; i++) begin
      idle_cycle();
      checkOutput($sformatf("rand drain %0d", i));
    end

    // Reset in the middle of a sweep.
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b0, 4'd0, 1'b1);
    checkOutput("abort start");
    for (int i = 0; i < 7; i++) begin
      idle_cycle();
      checkOutput($sformatf("abort pre %0d", i));
    end
    chk("abort at idx", 8'(bus.out_idx), 8'd6);
    rst_b = 1'b0;
    model_reset();
    #1;
    chk("abort out_valid", 8'(bus.out_valid), 8'd0);
    chk("abort out_data", 8'(bus.out_data), 8'd0);
    chk("abort out_idx", 8'(bus.out_idx), 8'd0);
    chk("abort sweep_done", 8'(bus.sweep_done), 8'd0);
    chk("abort sweep_busy", 8'(bus.sweep_busy), 8'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd3, 2'b11, 1'b1, 4'd3, 1'b1);
      checkOutput($sformatf("in reset %0d", i));
    end
    rst_b = 1'b1;
    applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 4'd9, 1'b0);
    checkOutput("first after reset");
    chk("first after reset valid", 8'(bus.out_valid), 8'd1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 4'd0, 2'd0, 1'b1, 4'(i), 1'b0);
      checkOutput($sformatf("cleared %0d", i));
      chk($sformatf("cleared data %0d", i), 8'(bus.out_data), 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lut_func_unit.md
LUT_FUNC_UNIT -- requirements
Module: lut_func_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter N_IN SHALL default to 4 and sets the number of function inputs (table depth 2^N_IN).
REQ-003 Parameter N_OUT SHALL default to 2 and sets the number of function outputs (table width).
REQ-004 Port clk SHALL be an input, 1 bit: rising-edge clock.
REQ-005 Port rst_b SHALL be an input, 1 bit: asynchronous active-low reset.
REQ-006 Port cfg_we SHALL be an input, 1 bit: table write strobe.
REQ-007 Port cfg_addr SHALL be an input, N_IN bits: table write address (input combination).
REQ-008 Port cfg_data SHALL be an input, N_OUT bits: output values for that combination.
REQ-009 Port in_valid SHALL be an input, 1 bit: single-evaluation request.
REQ-010 Port in_data SHALL be an input, N_IN bits: combination {i(N_IN-1)..i0} to evaluate.
REQ-011 Port sweep_start SHALL be an input, 1 bit: start an exhaustive sweep of all combinations.
REQ-012 Port out_valid SHALL be an output, 1 bit: out_data/out_idx valid this cycle.
REQ-013 Port out_data SHALL be an output, N_OUT bits: function outputs {o(N_OUT-1)..o0}.
REQ-014 Port out_idx SHALL be an output, N_IN bits: combination that produced out_data.
REQ-015 Port sweep_busy SHALL be an output, 1 bit: high while state is RUN.
REQ-016 Port sweep_done SHALL be an output, 1 bit: one-cycle pulse on the last sweep result.

Function
REQ-017 Table storage SHALL be 2^N_IN entries of N_OUT bits, implemented as registers.
REQ-018 When cfg_we=1 in IDLE, table[cfg_addr] SHALL take cfg_data at the clock edge; cfg_we in RUN SHALL be ignored.
REQ-019 When in_valid=1 in IDLE, the next edge SHALL produce out_valid=1, out_idx=in_data, out_data=table[in_data] (latency 1); otherwise out_valid SHALL be 0 in IDLE.
REQ-020 A same-cycle write and evaluation of the same address SHALL return the old table value; the new value is visible from the next cycle.
REQ-021 The FSM SHALL have two states: IDLE and RUN, with an N_IN-bit counter cnt.
REQ-022 On an edge with sweep_start=1 in IDLE, the FSM SHALL go to RUN with cnt=0; sweep_start SHALL take priority over in_valid, which is dropped that cycle.
REQ-023 On each edge in RUN, the block SHALL register out_valid=1, out_idx=cnt, out_data=table[cnt], and cnt=cnt+1.
REQ-024 On the RUN edge where cnt=2^N_IN-1, the FSM SHALL return to IDLE, cnt SHALL wrap to 0, and sweep_done SHALL be registered high for that one output cycle.
REQ-025 A sweep SHALL emit exactly 2^N_IN consecutive out_valid cycles with out_idx ascending 0..2^N_IN-1.
REQ-026 The first sweep output SHALL appear two edges after sweep_start is sampled.
REQ-027 In RUN, sweep_start and in_valid SHALL be ignored and no requests SHALL be queued.
REQ-028 sweep_busy SHALL be combinational from state (1 in RUN).
REQ-029 A new sweep_start on the edge that returns to IDLE SHALL be ignored; the earliest accepted restart is the following edge.

Reset
REQ-030 While rst_b=0, state SHALL be IDLE, cnt=0, every table entry 0, out_valid=0, out_data=0, out_idx=0, sweep_done=0.
REQ-031 Reset asserted mid-sweep SHALL abort the sweep immediately; no further out_valid or sweep_done is produced.
REQ-032 After rst_b deasserts, the first operation SHALL be accepted on the first rising edge.

Verification
REQ-033 Reset, then in_valid with in_data=4'b0101 -> next cycle out_valid=1, out_idx=5, out_data=2'b00.
REQ-034 Write table[k]={~k1^k0 as o1, ~k0 as o0} for k=0..15, then evaluate k=0,1,2,3 -> out_data=11,00,01,10.
REQ-035 Same-cycle cfg_we addr=7 data=11 and in_valid in_data=7 (table[7]=00) -> out_data=00; the next evaluation returns 11.
REQ-036 sweep_start pulse -> 16 consecutive out_valid cycles with out_idx 0..15 and data matching the table, sweep_done=1 only with out_idx=15, sweep_busy low afterwards.
REQ-037 in_valid, cfg_we and sweep_start applied during a sweep -> ignored, sweep sequence unchanged, table unchanged.
REQ-038 rst_b pulled low at out_idx=6 of a sweep -> outputs 0 at once, no sweep_done, table cleared, IDLE after release.
